// File: rtl/serie_paralelo_sync_rx.sv
// Receive-path deserializer: recovers word alignment from a repeated comma
// symbol on a 1-bit serial line and emits aligned words held between boundaries.
module serie_paralelo_sync_rx #(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] COM       = 4'hC,
   parameter int unsigned      COM_COUNT = 4
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             active
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ComW = $clog2(COM_COUNT + 1);
   localparam logic [CntW-1:0] LastBit   = CntW'(WIDTH - 1);
   localparam logic [ComW-1:0] ComTarget = ComW'(COM_COUNT);

   typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [ComW-1:0]   com_cnt_q, com_cnt_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              valid_q, valid_d;
   logic              active_q, active_d;

   logic [WIDTH-1:0]  window;
   logic              is_com;
   logic              boundary;

   // Window includes the bit arriving this cycle so a match is seen on its last bit.
   assign window   = {shift_q[WIDTH-2:0], data_in};
   assign is_com   = (window == COM);
   assign boundary = (bit_cnt_q == LastBit);

   // Next-state logic: comma search, alignment confirmation, and word capture.
   always_comb begin
      state_d   = state_q;
      shift_d   = window;
      bit_cnt_d = bit_cnt_q;
      com_cnt_d = com_cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      active_d  = active_q;

      unique case (state_q)
         StSearch: begin
            if (is_com) begin
               bit_cnt_d = '0;
               com_cnt_d = ComW'(1);
               if (COM_COUNT == 1) begin
                  state_d  = StActive;
                  active_d = 1'b1;
               end else begin
                  state_d = StAlign;
               end
            end
         end
         StAlign: begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
            if (boundary) begin
               if (is_com) begin
                  if (com_cnt_q != ComTarget) begin
                     com_cnt_d = com_cnt_q + 1'b1;
                  end
                  if (com_cnt_d == ComTarget) begin
                     state_d  = StActive;
                     active_d = 1'b1;
                  end
               end else begin
                  // Match was a false comma straddling words; slide again.
                  com_cnt_d = '0;
                  state_d   = StSearch;
               end
            end
         end
         StActive: begin
            bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
            if (boundary) begin
               if (is_com) begin
                  valid_d = 1'b0;
               end else begin
                  data_d  = window;
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = StSearch;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_32f) begin
      if (!reset_L) begin
         state_q   <= StSearch;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         active_q  <= active_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign active    = active_q;

endmodule

// File: tb/tb_serie_paralelo_sync_rx.sv
// Directed, table-driven bench for serie_paralelo_sync_rx (WIDTH=4, COM=C, COM_COUNT=4).
module tb_serie_paralelo_sync_rx;

   logic       clk_32f = 1'b0;
   logic       reset_L;
   logic       data_in;
   logic [3:0] data_out;
   logic       valid_out;
   logic       active;

   serie_paralelo_sync_rx #(
      .WIDTH    (4),
      .COM      (4'hC),
      .COM_COUNT(4)
   ) dut (
      .clk_32f  (clk_32f),
      .reset_L  (reset_L),
      .data_in  (data_in),
      .data_out (data_out),
      .valid_out(valid_out),
      .active   (active)
   );

   always #5 clk_32f = ~clk_32f;

   typedef struct {
      logic       rst_l;
      logic       din;
      logic [3:0] exp_d;
      logic       exp_v;
      logic       exp_a;
      int         tag;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   task automatic push(input logic r, input logic d, input logic [3:0] ed, input logic ev,
                       input logic ea, input int tag);
      vec_t v;
      v.rst_l = r;
      v.din   = d;
      v.exp_d = ed;
      v.exp_v = ev;
      v.exp_a = ea;
      v.tag   = tag;
      vecs.push_back(v);
   endtask

   // One word, MSB first; outputs expected old for bits 3..1 and new after the last bit.
   task automatic push_word(input logic [3:0] w, input logic [3:0] od, input logic ov,
                            input logic oa, input logic [3:0] nd, input logic nv,
                            input logic na, input int tag);
      for (int i = 3; i >= 1; i--) push(1'b1, w[i], od, ov, oa, tag);
      push(1'b1, w[0], nd, nv, na, tag);
   endtask

   task automatic check(input string name, input int idx, input int tag,
                        input logic [3:0] got, input logic [3:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s vec %0d tag %0d got %h want %h", name, idx, tag, got, want);
      end
   endtask

   initial begin
      logic [3:0] com;
      int         rise;
      com     = 4'hC;
      reset_L = 1'b0;
      data_in = 1'b0;

      // Tag 0: reset hold with random line, then release with idle zeros.
      for (int i = 0; i < 8; i++) push(1'b0, 1'($urandom), 4'h0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 0);

      // Tag 1: four commas; active rises on the 16th bit.
      for (int i = 0; i < 3; i++) push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 0, 1);
      push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 1, 1);

      // Tag 2: data after lock; comma drops valid and holds data.
      push_word(4'h5, 4'h0, 0, 1, 4'h5, 1, 1, 2);
      push_word(4'hA, 4'h5, 1, 1, 4'hA, 1, 1, 2);
      push_word(4'hC, 4'hA, 1, 1, 4'hA, 0, 1, 2);
      push_word(4'h3, 4'hA, 0, 1, 4'h3, 1, 1, 2);

      // Tag 3: reset while active holding A, then full re-lock and one word.
      push_word(4'hA, 4'h3, 1, 1, 4'hA, 1, 1, 3);
      push(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3);
      for (int i = 0; i < 3; i++) push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 0, 3);
      push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 1, 3);
      push_word(4'h5, 4'h0, 0, 1, 4'h5, 1, 1, 3);

      // Tag 4: two junk bits before the commas, then 9.
      push(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4);
      push(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4);
      push(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 4);
      for (int i = 0; i < 3; i++) push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 0, 4);
      push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 1, 4);
      push_word(4'h9, 4'h0, 0, 1, 4'h9, 1, 1, 4);

      // Tag 5: two commas, a 6 breaks alignment, then four commas lock.
      push(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5);
      push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 0, 5);
      push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 0, 5);
      push_word(4'h6, 4'h0, 0, 0, 4'h0, 0, 0, 5);
      for (int i = 0; i < 3; i++) push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 0, 5);
      push_word(4'hC, 4'h0, 0, 0, 4'h0, 0, 1, 5);

      foreach (vecs[i]) begin
         @(negedge clk_32f);
         reset_L = vecs[i].rst_l;
         data_in = vecs[i].din;
         @(posedge clk_32f);
         #1;
         check("data_out", i, vecs[i].tag, data_out, vecs[i].exp_d);
         check("valid_out", i, vecs[i].tag, {3'b0, valid_out}, {3'b0, vecs[i].exp_v});
         check("active", i, vecs[i].tag, {3'b0, active}, {3'b0, vecs[i].exp_a});
      end

      // Hand sequence: continuous commas after reset, bounded wait for lock.
      @(negedge clk_32f);
      reset_L = 1'b0;
      data_in = 1'b0;
      @(posedge clk_32f);
      rise = -1;
      for (int c = 1; c <= 40 && rise < 0; c++) begin
         @(negedge clk_32f);
         reset_L = 1'b1;
         data_in = com[3 - ((c - 1) % 4)];
         @(posedge clk_32f);
         #1;
         if (active) rise = c;
      end
      checks++;
      if (rise != 16) begin
         errors++;
         $display("FAIL lock_cycle got %0d want 16", rise);
      end
      // Commas while locked must never raise valid or change data.
      for (int c = 17; c <= 28; c++) begin
         @(negedge clk_32f);
         data_in = com[3 - ((c - 1) % 4)];
         @(posedge clk_32f);
         #1;
         check("idle_valid", c, 6, {3'b0, valid_out}, 4'h0);
         check("idle_data", c, 6, data_out, 4'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
